// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem initiator: FSM state encoding and bus constants.
package iomem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [3:0]  WSTRB_READ        = 4'b0000;
    localparam logic [31:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/iomem_timeout.sv
// Counts bus cycles without iomem_ready; expired flags the final allowed cycle.
module iomem_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Combinational so the FSM can act in the same cycle as the last idle wait.
    assign expired = enable && (count == LAST);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/iomem_master.sv
// Single-outstanding iomem bus initiator with per-transaction timeout.
// Handshakes: a transfer occurs on a rising CLK edge where valid and ready are both high.
module iomem_master
    import iomem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = DEFAULT_ERR_RDATA
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        iomem_valid,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic        iomem_ready,
    input  logic [31:0] iomem_rdata,
    output state_e      state_dbg
);

    state_e state;
    logic   tmo_clear;
    logic   tmo_enable;
    logic   tmo_expired;

    assign tmo_clear  = (state != ST_BUS);
    assign tmo_enable = (state == ST_BUS) && !iomem_ready;

    iomem_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    // Gated by RST so no command is offered while reset is held.
    assign cmd_ready = (state == ST_IDLE) && !RST;
    assign state_dbg = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            iomem_valid <= 1'b0;
            iomem_addr  <= '0;
            iomem_wdata <= '0;
            iomem_wstrb <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        state       <= ST_BUS;
                        iomem_valid <= 1'b1;
                        iomem_addr  <= cmd_addr;
                        iomem_wdata <= cmd_wdata;
                        iomem_wstrb <= cmd_wstrb;
                    end
                end
                ST_BUS: begin
                    // Ready wins over a simultaneous timeout.
                    if (iomem_ready || tmo_expired) begin
                        state       <= ST_RESP;
                        iomem_valid <= 1'b0;
                        iomem_addr  <= '0;
                        iomem_wdata <= '0;
                        iomem_wstrb <= '0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= iomem_ready ? iomem_rdata : ERR_RDATA;
                        rsp_err     <= !iomem_ready;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_master.sv
// Directed bench for iomem_master: per-cycle timeline model plus response scoreboard.
module tb_iomem_master;
    import iomem_pkg::*;

    localparam int T = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        iomem_valid;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic        iomem_ready;
    logic [31:0] iomem_rdata;
    state_e      state_dbg;

    iomem_master #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_wstrb  (cmd_wstrb),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .iomem_valid(iomem_valid),
        .iomem_wstrb(iomem_wstrb),
        .iomem_addr (iomem_addr),
        .iomem_wdata(iomem_wdata),
        .iomem_ready(iomem_ready),
        .iomem_rdata(iomem_rdata),
        .state_dbg  (state_dbg)
    );

    // Clock / reset
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected per-cycle outputs, set by the driver from the transaction timeline.
    bit          exp_check = 1'b0;
    logic        exp_cmd_ready;
    logic        exp_iovalid;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic        exp_rsp_valid;
    logic [31:0] exp_rdata;
    logic        exp_err;

    logic [32:0] exp_q[$];
    int          burst;

    always @(negedge CLK) begin
        if (exp_check) begin
            check("cmd_ready", 32'(cmd_ready), 32'(exp_cmd_ready));
            check("iomem_valid", 32'(iomem_valid), 32'(exp_iovalid));
            check("iomem_addr", iomem_addr, exp_addr);
            check("iomem_wdata", iomem_wdata, exp_wdata);
            check("iomem_wstrb", 32'(iomem_wstrb), 32'(exp_wstrb));
            check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
            if (exp_rsp_valid) begin
                check("rsp_rdata_cyc", rsp_rdata, exp_rdata);
                check("rsp_err_cyc", 32'(rsp_err), 32'(exp_err));
            end
            if (iomem_valid === 1'b1) burst++;
            // Scoreboard: each response handshake retires one expected response.
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                check("rsp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("sb_rdata", rsp_rdata, e[31:0]);
                    check("sb_err", 32'(rsp_err), 32'(e[32]));
                end
            end
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          rdelay;    // valid cycles before ready; -1 = responder silent
        logic [31:0] rdata;
        int          hold;      // cycles rsp_ready is held low
        bit          noise;     // stray iomem_ready / rsp_ready outside their phases
        int          lit_burst; // hand-computed iomem_valid burst length
    } vec_t;

    // Driver
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            cmd_valid     = 1'b0;
            cmd_addr      = $urandom;
            cmd_wdata     = $urandom;
            cmd_wstrb     = 4'($urandom_range(0, 15));
            iomem_ready   = 1'($urandom_range(0, 1));
            iomem_rdata   = $urandom;
            rsp_ready     = 1'($urandom_range(0, 1));
            exp_check     = 1'b1;
            exp_cmd_ready = 1'b1;
            exp_iovalid   = 1'b0;
            exp_addr      = '0;
            exp_wdata     = '0;
            exp_wstrb     = '0;
            exp_rsp_valid = 1'b0;
            exp_rdata     = '0;
            exp_err       = 1'b0;
        end
    endtask

    task automatic run_tx(input vec_t v, input int abort_at);
        bit err;
        int bus_len;
        int total;
        err     = (v.rdelay < 0) || (v.rdelay >= T);
        bus_len = err ? T : v.rdelay + 1;
        total   = bus_len + 2 + v.hold;
        if (abort_at < 0) exp_q.push_back({err, err ? 32'hDEAD_BEEF : v.rdata});
        for (int c = 0; c < total; c++) begin
            @(posedge CLK); #1;
            if (c == abort_at) begin
                exp_check   = 1'b0;
                cmd_valid   = 1'b0;
                iomem_ready = 1'b0;
                rsp_ready   = 1'b0;
                #2 RST = 1'b1;
                #1;
                check("rst_iomem_valid", 32'(iomem_valid), 32'd0);
                check("rst_iomem_addr", iomem_addr, 32'd0);
                check("rst_iomem_wdata", iomem_wdata, 32'd0);
                check("rst_iomem_wstrb", 32'(iomem_wstrb), 32'd0);
                check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
                check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
                for (int k = 0; k < 2; k++) begin
                    @(negedge CLK);
                    check("rst_hold_rsp_valid", 32'(rsp_valid), 32'd0);
                    check("rst_hold_iomem_valid", 32'(iomem_valid), 32'd0);
                end
                @(posedge CLK); #3 RST = 1'b0;
                return;
            end
            if (c == 0) burst = 0;
            cmd_valid   = (c == 0);
            cmd_addr    = (c == 0) ? v.addr  : $urandom;
            cmd_wdata   = (c == 0) ? v.wdata : $urandom;
            cmd_wstrb   = (c == 0) ? v.wstrb : 4'($urandom_range(0, 15));
            iomem_ready = (v.rdelay >= 0 && c == v.rdelay + 1) ||
                          (v.noise && (c == 0 || c > bus_len));
            iomem_rdata = (v.rdelay >= 0 && c == v.rdelay + 1) ? v.rdata : $urandom;
            rsp_ready   = (c == bus_len + 1 + v.hold) || (v.noise && c >= 1 && c <= bus_len);
            exp_check     = 1'b1;
            exp_cmd_ready = (c == 0);
            exp_iovalid   = (c >= 1) && (c <= bus_len);
            exp_addr      = exp_iovalid ? v.addr  : 32'h0;
            exp_wdata     = exp_iovalid ? v.wdata : 32'h0;
            exp_wstrb     = exp_iovalid ? v.wstrb : 4'h0;
            exp_rsp_valid = (c > bus_len);
            exp_rdata     = err ? 32'hDEAD_BEEF : v.rdata;
            exp_err       = err;
        end
        @(negedge CLK); #1;
        check("burst_len", 32'(burst), 32'(v.lit_burst));
    endtask

    // Stimulus
    vec_t vecs[8];

    initial begin
        RST         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_addr    = '0;
        cmd_wdata   = '0;
        cmd_wstrb   = '0;
        rsp_ready   = 1'b0;
        iomem_ready = 1'b0;
        iomem_rdata = '0;

        vecs[0] = '{32'h0300_0000, 32'h1122_3344, 4'b1111,     1, 32'h5555_0001, 0, 1'b0, 2};
        vecs[1] = '{32'h0300_0010, 32'h0000_0000, WSTRB_READ,  3, 32'hA5A5_1234, 0, 1'b0, 4};
        vecs[2] = '{32'h0300_0020, 32'hCAFE_0001, 4'b0011,    -1, 32'h0000_0000, 1, 1'b0, 16};
        vecs[3] = '{32'h0300_0030, 32'h0000_0000, WSTRB_READ, 15, 32'h1357_9BDF, 0, 1'b0, 16};
        vecs[4] = '{32'h0300_0040, 32'h89AB_CDEF, 4'b1000,     0, 32'h0F0F_F0F0, 5, 1'b1, 1};
        vecs[5] = '{32'h0300_0044, 32'h0000_0000, WSTRB_READ,  0, 32'h7654_3210, 0, 1'b1, 1};
        vecs[6] = '{32'h0300_0048, 32'h0000_0000, WSTRB_READ, 20, 32'h1111_2222, 4, 1'b1, 16};
        vecs[7] = '{32'h0300_0050, 32'hFEED_0002, 4'b0101,     2, 32'h3333_4444, 0, 1'b0, 3};

        #12;
        check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset_iomem_valid", 32'(iomem_valid), 32'd0);
        check("reset_iomem_addr", iomem_addr, 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_rdata", rsp_rdata, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        #11 RST = 1'b0;

        idle(2);
        for (int i = 0; i < 7; i++) run_tx(vecs[i], -1);
        idle(1);
        run_tx(vecs[2], 3);
        idle(2);
        run_tx(vecs[7], -1);
        idle(2);

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iomem_master.md
IOMEM_MASTER -- requirements
Module: iomem_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: bus cycles to wait for iomem_ready before an error response; legal range 2..65535.
REQ-002 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF: rsp_rdata value returned on timeout.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port CLK, input, 1: sole clock, rising edge.
REQ-005 SHALL have port RST, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1: command request.
REQ-007 SHALL have port cmd_ready, output, 1: command accepted when high together with cmd_valid.
REQ-008 SHALL have port cmd_addr, input, 32: target byte address.
REQ-009 SHALL have port cmd_wdata, input, 32: write data.
REQ-010 SHALL have port cmd_wstrb, input, 4: byte enables; 4'b0000 means read.
REQ-011 SHALL have port rsp_valid, output, 1: response available.
REQ-012 SHALL have port rsp_ready, input, 1: response consumed when high together with rsp_valid.
REQ-013 SHALL have port rsp_rdata, output, 32: read data, or ERR_RDATA on timeout.
REQ-014 SHALL have port rsp_err, output, 1: high if the transaction timed out.
REQ-015 SHALL have ports iomem_valid (output, 1), iomem_wstrb (output, 4), iomem_addr (output, 32), iomem_wdata (output, 32), iomem_ready (input, 1) and iomem_rdata (input, 32): initiator side of the iomem bus.

Function
REQ-016 SHALL implement the FSM IDLE -> BUS -> RESP -> IDLE; cmd_ready SHALL be high iff state==IDLE.
REQ-017 SHALL, in IDLE on cmd_valid&&cmd_ready, register addr/wdata/wstrb and enter BUS; iomem_valid SHALL be high from the next cycle.
REQ-018 SHALL hold iomem_addr, iomem_wdata and iomem_wstrb constant while iomem_valid is high; outside BUS these outputs SHALL be 0.
REQ-019 SHALL, in BUS on the first cycle with iomem_ready high, capture iomem_rdata into rsp_rdata, clear rsp_err, and deassert iomem_valid on the next cycle; rsp_valid SHALL also rise on that next cycle (one cycle after the ready sample).
REQ-020 SHALL count BUS cycles with iomem_ready low; when TIMEOUT_CYCLES such cycles elapse, it SHALL drop iomem_valid, set rsp_err=1, set rsp_rdata=ERR_RDATA and enter RESP.
REQ-021 SHALL give iomem_ready priority over timeout when both occur in the same cycle (success response).
REQ-022 SHALL ignore iomem_ready outside BUS.
REQ-023 SHALL keep rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready; on handshake it SHALL enter IDLE, with cmd_ready high the following cycle and no command accepted in the handshake cycle.
REQ-024 SHALL report the rsp_rdata value for writes as captured iomem_rdata (don't-care to the consumer, but deterministic).
REQ-025 SHALL issue exactly one iomem transaction per accepted command; the maximum rate SHALL be one transaction per 3 cycles.

Reset
REQ-026 SHALL, while RST is high, force state=IDLE, iomem_valid=0, iomem_addr/wdata/wstrb=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, timeout count=0, and cmd_ready=0.
REQ-027 SHALL abandon an in-flight BUS or RESP transaction on RST assertion, with no response delivered.

Structure
REQ-028 SHALL place the state encoding (IDLE/BUS/RESP), the read-wstrb constant 4'b0000 and the default ERR_RDATA in shared package iomem_pkg.
REQ-029 SHALL implement the timeout counter as sub-module iomem_timeout (clear, enable, expired), sized $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-030 SHALL cover: write addr 0x0300_0000, wdata 0x1122_3344, wstrb 4'b1111, responder ready 1 cycle after valid -> one iomem_valid burst of 2 cycles, then rsp_valid=1 with rsp_err=0.
REQ-031 SHALL cover: read with wstrb 0, responder returns 0xA5A5_1234 after 3 cycles -> rsp_rdata=0xA5A5_1234, rsp_err=0, iomem_wstrb=0 throughout.
REQ-032 SHALL cover: TIMEOUT_CYCLES=16, responder silent -> iomem_valid high exactly 16 cycles, then rsp_err=1 and rsp_rdata=0xDEAD_BEEF.
REQ-033 SHALL cover: TIMEOUT_CYCLES=16, ready asserted on the 16th bus cycle -> success response with rsp_err=0.
REQ-034 SHALL cover: rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready low, no new iomem_valid; cmd_ready rises the cycle after the handshake.
REQ-035 SHALL cover: RST pulsed mid-BUS -> iomem_valid=0 immediately (asynchronous), no rsp_valid, and the next command executes normally.
